// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: sequencer state and fault encodings shared by the sequencer and its bench.
package cpu_seq_pkg;
  localparam int SEQ_STATE_WIDTH = 3;
  typedef enum logic [SEQ_STATE_WIDTH-1:0] {
    SEQ_FETCH,
    SEQ_EXEC,
    SEQ_MEM,
    SEQ_WB,
    SEQ_HALT
  } seq_state_e;
  typedef enum logic [1:0] {
    FAULT_NONE,
    FAULT_ILLEGAL,
    FAULT_MISALIGN,
    FAULT_TIMEOUT
  } fault_e;
endpackage

// File: rtl/cpu_seq_wait_timer.sv
// cpu_seq_wait_timer: saturating count of un-acked request cycles; expired flags the
// cycle that would be the WAIT_LIMIT-th un-acked one (WAIT_LIMIT=0 never expires).
module cpu_seq_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int unsigned W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [W-1:0] LAST = W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = i_clr ? '0 : (i_en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  assign o_expired = (WAIT_LIMIT != 0) && i_en && (cnt_q >= LAST);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle FETCH/EXEC/MEM/WB sequencer for the RV32 core; owns PC and IR,
// drives the memory handshakes and retires exactly one instruction at a time.
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic        i_is_branch,
  input  logic        i_is_jump,
  input  logic        i_wb_en,
  input  logic        i_illegal,
  input  logic        i_cmp_res,
  input  logic [31:0] i_alu_res,
  output logic [31:0] o_alu_q,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  output logic        o_rf_we,
  output logic [31:0] o_pc,
  output logic        o_retire,
  output logic        o_halted,
  output logic [1:0]  o_fault
);
  seq_state_e  state_q, state_d;
  fault_e      fault_q, fault_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, alu_q, alu_d, npc;
  logic        waiting, ack, expired;
  assign waiting = (state_q == SEQ_FETCH) || (state_q == SEQ_MEM);
  assign ack     = (state_q == SEQ_FETCH) ? i_imem_ack : i_dmem_ack;
  assign npc     = (i_is_jump || (i_is_branch && i_cmp_res)) ? alu_q : pc_q + 32'd4;
  cpu_seq_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (!waiting),
    .i_en     (waiting && !ack),
    .o_expired(expired)
  );
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    alu_d   = alu_q;
    case (state_q)
      SEQ_FETCH: if (i_imem_ack) begin
        instr_d = i_imem_rdata;
        state_d = SEQ_EXEC;
      end
      SEQ_EXEC: if (i_illegal) begin
        state_d = SEQ_HALT;
        fault_d = FAULT_ILLEGAL;
      end else begin
        alu_d   = i_alu_res;
        state_d = (i_is_load || i_is_store) ? SEQ_MEM : SEQ_WB;
      end
      SEQ_MEM: if (i_dmem_ack) state_d = SEQ_WB;
      SEQ_WB: if (npc[1:0] != 2'b00) begin
        state_d = SEQ_HALT;
        fault_d = FAULT_MISALIGN;
      end else begin
        pc_d    = npc;
        state_d = SEQ_FETCH;
      end
      default: ;
    endcase
    // expired already excludes an ack in the same cycle, so ack wins the race
    if (expired) begin
      state_d = SEQ_HALT;
      fault_d = FAULT_TIMEOUT;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SEQ_FETCH;
      fault_q <= FAULT_NONE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      alu_q   <= alu_d;
    end
  end
  // reset itself masks the fetch request so an abandoned fetch drops immediately
  assign o_imem_req  = i_rst_n && (state_q == SEQ_FETCH);
  assign o_imem_addr = pc_q;
  assign o_instr     = instr_q;
  assign o_alu_q     = alu_q;
  assign o_dmem_req  = state_q == SEQ_MEM;
  assign o_dmem_we   = (state_q == SEQ_MEM) && i_is_store;
  assign o_rf_we     = (state_q == SEQ_WB) && i_wb_en && !i_is_store;
  assign o_retire    = state_q == SEQ_WB;
  assign o_halted    = state_q == SEQ_HALT;
  assign o_pc        = pc_q;
  assign o_fault     = fault_q;
endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: bench acting as memories and decoder; each instruction is checked against
// a transaction-level model of PC flow, latency, strobe counts and faults.
module tb_cpu_seq;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int WL = 4;
  logic        i_clk = 0, i_rst_n = 0;
  logic        o_imem_req, i_imem_ack = 0;
  logic [31:0] o_imem_addr, i_imem_rdata = 0, o_instr, i_alu_res = 0, o_alu_q, o_pc;
  logic        i_is_load = 0, i_is_store = 0, i_is_branch = 0, i_is_jump = 0;
  logic        i_wb_en = 0, i_illegal = 0, i_cmp_res = 0;
  logic        o_dmem_req, o_dmem_we, i_dmem_ack = 0, o_rf_we, o_retire, o_halted;
  logic [1:0]  o_fault;
  int          errors = 0, checks = 0;
  logic [31:0] m_pc, m_instr, m_aluq;
  logic        m_halted;

  cpu_seq #(.RESET_PC(RST_PC), .WAIT_LIMIT(WL)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ack(i_imem_ack),
    .i_imem_rdata(i_imem_rdata), .o_instr(o_instr),
    .i_is_load(i_is_load), .i_is_store(i_is_store), .i_is_branch(i_is_branch),
    .i_is_jump(i_is_jump), .i_wb_en(i_wb_en), .i_illegal(i_illegal),
    .i_cmp_res(i_cmp_res), .i_alu_res(i_alu_res), .o_alu_q(o_alu_q),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .i_dmem_ack(i_dmem_ack),
    .o_rf_we(o_rf_we), .o_pc(o_pc), .o_retire(o_retire), .o_halted(o_halted),
    .o_fault(o_fault)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset;
    i_rst_n = 0;
    i_imem_ack = 0;
    i_dmem_ack = 0;
    @(negedge i_clk);
    check("rst_pc", o_pc, RST_PC);
    check("rst_instr", o_instr, 0);
    check("rst_aluq", o_alu_q, 0);
    check("rst_fault", o_fault, 0);
    check("rst_strobes", {o_imem_req, o_dmem_req, o_dmem_we, o_rf_we, o_retire, o_halted}, 0);
    @(posedge i_clk);
    #1 i_rst_n = 1;
    m_pc = RST_PC;
    m_instr = 0;
    m_aluq = 0;
    m_halted = 0;
  endtask

  // fd/md: number of un-acked req cycles before the ack (>= WL means it never comes in time)
  task automatic run_instr(input int fd, input int md, input logic ld, input logic st,
                           input logic br, input logic jp, input logic wbe, input logic ill,
                           input logic cmp, input logic [31:0] alu, input logic [31:0] rdata);
    int cyc, ireq, dreq, dwe, ret, rfw, e_fault, e_dreq;
    logic done, mem, fetched, execd, retired;
    logic [31:0] npc;
    {i_is_load, i_is_store, i_is_branch, i_is_jump, i_wb_en, i_illegal, i_cmp_res} =
      {ld, st, br, jp, wbe, ill, cmp};
    i_alu_res = alu;
    i_imem_rdata = rdata;
    cyc = 0; ireq = 0; dreq = 0; dwe = 0; ret = 0; rfw = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge i_clk);
      i_imem_ack = 0;
      i_dmem_ack = 0;
      if (o_halted) done = 1;
      else begin
        cyc++;
        if (o_imem_req) begin
          ireq++;
          if (ireq == 1) check("imem_addr", o_imem_addr, m_pc);
          i_imem_ack = (ireq == fd + 1);
        end
        if (o_dmem_req) begin
          dreq++;
          if (o_dmem_we) dwe++;
          i_dmem_ack = (dreq == md + 1);
        end
        if (o_rf_we) rfw++;
        if (o_retire) begin
          ret++;
          @(posedge i_clk);
          #1 done = 1;
        end
      end
    end
    mem = ld | st;
    fetched = fd < WL;
    execd = fetched && !ill;
    e_fault = !fetched ? 3 : ill ? 1 : (mem && md >= WL) ? 3 : 0;
    npc = (jp || (br && cmp)) ? alu : m_pc + 32'd4;
    if (e_fault == 0 && npc[1:0] != 2'b00) e_fault = 2;
    retired = (e_fault == 0) || (e_fault == 2);
    e_dreq = (!execd || !mem) ? 0 : (md >= WL) ? WL : md + 1;
    if (fetched) m_instr = rdata;
    if (execd) m_aluq = alu;
    if (e_fault == 0) m_pc = npc;
    m_halted = e_fault != 0;
    check("done", done, 1);
    check("ireq_cycles", ireq, fetched ? fd + 1 : WL);
    check("dreq_cycles", dreq, e_dreq);
    check("dwe_cycles", dwe, st ? e_dreq : 0);
    check("retire", ret, retired);
    check("rf_we", rfw, retired && wbe && !st);
    if (retired) check("latency", cyc, fd + 3 + (mem ? md + 1 : 0));
    check("pc", o_pc, m_pc);
    check("fault", o_fault, e_fault);
    check("halted", o_halted, m_halted);
    check("instr", o_instr, m_instr);
    check("aluq", o_alu_q, m_aluq);
  endtask

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++) begin
      int kind, fd, md;
      logic [31:0] r, alu;
      logic ld, st, br, jp, ill, wbe, cmp;
      kind = $urandom_range(0, 19);
      fd = ($urandom_range(0, 11) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      md = ($urandom_range(0, 11) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      r = $urandom;
      alu = {r[31:2], ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00};
      ld = kind inside {[8:10]};
      st = kind inside {[11:13]};
      br = kind inside {[14:16]};
      jp = kind inside {17, 18};
      ill = kind == 19;
      wbe = st ? 1'($urandom_range(0, 1)) : !br;
      cmp = 1'($urandom_range(0, 1));
      run_instr(fd, md, ld, st, br, jp, wbe, ill, cmp, alu, $urandom);
      if (m_halted) do_reset;
    end
  endtask

  initial begin
    int idle_req;
    logic reached;
    do_reset;
    run_instr(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0105, 32'h0050_0093);
    run_instr(0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0000_0200, 32'h0fc0_006f);
    run_instr(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0000_0040, 32'hfc00_0ee3);
    run_instr(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0000_0080, 32'h0000_0463);
    run_instr(0, 3, 0, 1, 0, 0, 1, 0, 0, 32'h0000_1000, 32'h0011_2023);
    run_instr(0, 0, 1, 0, 0, 0, 1, 0, 0, 32'h0000_1000, 32'h0001_2083);
    run_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0000, 32'hffff_ffff);
    idle_req = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      i_imem_ack = 1;
      if (o_imem_req) idle_req++;
    end
    i_imem_ack = 0;
    check("halt_no_req", idle_req, 0);
    check("halt_fault_held", o_fault, 1);
    do_reset;
    run_instr(0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0000_0202, 32'h1000_006f);
    do_reset;
    run_instr(1000, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0001, 32'h0010_0093);
    do_reset;
    run_instr(3, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0001, 32'h0010_0093);
    run_instr(0, 1000, 1, 0, 0, 0, 1, 0, 0, 32'h0000_2000, 32'h0001_2083);
    do_reset;
    {i_is_load, i_is_store, i_is_branch, i_is_jump, i_wb_en, i_illegal} = 6'b100010;
    reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      @(negedge i_clk);
      i_imem_ack = o_imem_req;
      if (o_dmem_req) reached = 1;
    end
    i_imem_ack = 0;
    check("mem_reached", reached, 1);
    #2 i_rst_n = 0;
    #1;
    check("rst_dreq_drop", o_dmem_req, 0);
    check("rst_ireq_low", o_imem_req, 0);
    check("rst_pc_async", o_pc, RST_PC);
    do_reset;
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0003, 32'h0030_0093);
    run_random(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
